// File: rtl/sync_pkg.sv
// Shared defaults and sizing helper for the sync_debounce block.
package sync_pkg;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int SYNC_DB_CYCLES_DEF = 16;

    // Bits needed to hold 0..db_cycles.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// One channel's plain flop-chain synchronizer; no logic between stages.
module sync_chain
    import sync_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debounce with registered rise/fall pulses.
// Define SYNC_DEBOUNCE_EN to enable the per-channel debounce counters.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int STAGES    = SYNC_STAGES_DEF,
    parameter int DB_CYCLES = SYNC_DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_debounce: WIDTH out of range");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_debounce: STAGES out of range");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db
        $error("sync_debounce: DB_CYCLES out of range");
    end

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        sync_chain #(
            .STAGES(STAGES)
        ) u_chain (
            .clk(clk),
            .rst(rst),
            .d  (sig_in[i]),
            .q  (s[i])
        );
    end

`ifdef SYNC_DEBOUNCE_EN
    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          mismatch;

        assign mismatch = s[i] != out_q[i];

        // Counter clears on agreement and on acceptance, so it never passes CNT_MAX.
        always_ff @(posedge clk) begin
            if (rst || !mismatch || cnt_q == CNT_MAX) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign out_d[i] = (mismatch && cnt_q == CNT_MAX) ? s[i] : out_q[i];
    end
`else
    assign out_d = s;
`endif

    // Pulses are registered alongside the level so they line up with the new sig_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            out_q  <= out_d;
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign sig_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed, table-driven bench for sync_debounce (WIDTH=4, STAGES=2, DB_CYCLES=4).
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EN
    localparam int LAT     = 6;
    localparam int PRE_RST = 4;
    localparam int G3_RISE = 0;
    localparam int G4_RISE_AT = 6;
    localparam int G4_FALL_AT = 10;
    localparam int CHAT_N  = 0;
`else
    localparam int LAT     = 3;
    localparam int PRE_RST = 1;
    localparam int G3_RISE = 1;
    localparam int G4_RISE_AT = 3;
    localparam int G4_FALL_AT = 7;
    localparam int CHAT_N  = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sig_in = 4'h0;
    logic [3:0] sig_out, rise, fall;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        logic [3:0] drise;
        logic [3:0] dfall;
    } vec_t;

    vec_t tbl[7];

    sync_debounce #(
        .WIDTH    (4),
        .STAGES   (2),
        .DB_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .sig_out(sig_out),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] prev;
        int rc, fc, rise_at, fall_at;

        tbl[0] = '{4'h9, 4'h9, 4'h0, 4'h6};
        tbl[1] = '{4'h3, 4'h3, 4'h2, 4'h8};
        tbl[2] = '{4'h5, 4'h5, 4'h4, 4'h2};
        tbl[3] = '{4'h3, 4'h3, 4'h2, 4'h4};
        tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h3};
        tbl[5] = '{4'hA, 4'hA, 4'hA, 4'h0};
        tbl[6] = '{4'h0, 4'h0, 4'h0, 4'hA};

        // Reset held with all inputs high, then the release step arrives LAT edges later.
        rst = 1'b1;
        sig_in = 4'hF;
        for (int t = 0; t < 3; t++) begin
            step();
            check("rst_out", sig_out, 4'h0);
            check("rst_rise", rise, 4'h0);
            check("rst_fall", fall, 4'h0);
        end
        rst = 1'b0;
        for (int t = 1; t <= LAT + 1; t++) begin
            step();
            if (t < LAT) begin
                check("rel_out_early", sig_out, 4'h0);
                check("rel_rise_early", rise, 4'h0);
            end else if (t == LAT) begin
                check("rel_out", sig_out, 4'hF);
                check("rel_rise", rise, 4'hF);
                check("rel_fall", fall, 4'h0);
            end else begin
                check("rel_rise_width", rise, 4'h0);
                check("rel_out_hold", sig_out, 4'hF);
            end
        end

        // Settled-state steps, including simultaneous rise and fall on different channels.
        prev = 4'hF;
        for (int v = 0; v < 7; v++) begin
            sig_in = tbl[v].din;
            for (int t = 1; t <= LAT + 1; t++) begin
                step();
                if (t < LAT) begin
                    check($sformatf("v%0d_out_early", v), sig_out, prev);
                    check($sformatf("v%0d_rise_early", v), rise, 4'h0);
                    check($sformatf("v%0d_fall_early", v), fall, 4'h0);
                end else if (t == LAT) begin
                    check($sformatf("v%0d_out", v), sig_out, tbl[v].dout);
                    check($sformatf("v%0d_rise", v), rise, tbl[v].drise);
                    check($sformatf("v%0d_fall", v), fall, tbl[v].dfall);
                end else begin
                    check($sformatf("v%0d_rise_width", v), rise, 4'h0);
                    check($sformatf("v%0d_fall_width", v), fall, 4'h0);
                end
            end
            prev = tbl[v].dout;
        end

        // Three-cycle glitch on channel 0.
        rc = 0;
        fc = 0;
        for (int t = 1; t <= 16; t++) begin
            sig_in = (t <= 3) ? 4'h1 : 4'h0;
            step();
            rc += int'(rise[0]);
            fc += int'(fall[0]);
        end
        check("glitch3_rise_cnt", rc, G3_RISE);
        check("glitch3_fall_cnt", fc, G3_RISE);
        check("glitch3_out", sig_out, 4'h0);

        // Four-cycle pulse on channel 0: exactly one rise and one fall at fixed edges.
        rc = 0;
        fc = 0;
        rise_at = -1;
        fall_at = -1;
        for (int t = 1; t <= 20; t++) begin
            sig_in = (t <= 4) ? 4'h1 : 4'h0;
            step();
            if (rise[0]) begin
                rc++;
                rise_at = t;
            end
            if (fall[0]) begin
                fc++;
                fall_at = t;
            end
        end
        check("pulse4_rise_cnt", rc, 1);
        check("pulse4_fall_cnt", fc, 1);
        check("pulse4_rise_at", rise_at, G4_RISE_AT);
        check("pulse4_fall_at", fall_at, G4_FALL_AT);

        // Chatter every cycle on channel 0 for 20 cycles.
        rc = 0;
        fc = 0;
        for (int t = 0; t < 30; t++) begin
            sig_in = (t < 20 && (t % 2) == 0) ? 4'h1 : 4'h0;
            step();
            rc += int'(rise[0]);
            fc += int'(fall[0]);
        end
        check("chatter_rise_cnt", rc, CHAT_N);
        check("chatter_fall_cnt", fc, CHAT_N);
        check("chatter_out", sig_out, 4'h0);

        // Reset in the middle of a pending change on channel 3.
        sig_in = 4'h8;
        for (int t = 0; t < PRE_RST; t++) begin
            step();
            check("abort_pre_rise", rise, 4'h0);
            check("abort_pre_out", sig_out, 4'h0);
        end
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            step();
            check("abort_rst_out", sig_out, 4'h0);
            check("abort_rst_rise", rise, 4'h0);
            check("abort_rst_fall", fall, 4'h0);
        end
        rst = 1'b0;
        for (int t = 1; t <= LAT + 1; t++) begin
            step();
            if (t < LAT) begin
                check("abort_rise_early", rise, 4'h0);
                check("abort_out_early", sig_out, 4'h0);
            end else if (t == LAT) begin
                check("abort_rise", rise, 4'h8);
                check("abort_out", sig_out, 4'h8);
            end else begin
                check("abort_rise_width", rise, 4'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
